// File: rtl/mcu51_pkg.sv
// Shared SFR definitions for the MCU51 port bank: register selects, reset value and the
// byte/bit write-merge helper used by every bit-addressable register.
package mcu51_pkg;

    localparam logic [1:0] REG_LATCH = 2'd0;
    localparam logic [1:0] REG_MASK  = 2'd1;
    localparam logic [1:0] REG_FLAG  = 2'd2;
    localparam logic [1:0] REG_RSVD  = 2'd3;

    localparam logic [7:0] PORT_RESET = 8'hFF;

    // Byte access replaces the whole register; bit access writes every set position bit.
    function automatic logic [7:0] sfr_bit_write(
        input logic       bb,
        input logic [7:0] position,
        input logic [7:0] din,
        input logic       bin,
        input logic [7:0] old
    );
        return bb ? din : ((old & ~position) | (position & {8{bin}}));
    endfunction

endpackage

// File: rtl/mcu_port_slice.sv
// One 8-bit quasi-bidirectional port: output latch, strong pull-up pulse, pin synchroniser,
// falling-edge flags with W1C clear, and interrupt mask.
module mcu_port_slice
    import mcu51_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en_i,
    input  logic [1:0] reg_sel_i,
    input  logic       bb_i,
    input  logic [7:0] position_i,
    input  logic [7:0] din_i,
    input  logic       bin_i,
    input  logic [7:0] pin_i,
    output logic [7:0] latch_o,
    output logic [7:0] mask_o,
    output logic [7:0] flag_o,
    output logic [7:0] sync_o,
    output logic [7:0] pin_out_o,
    output logic [7:0] pin_oe_o
);

    logic [7:0] latch_q, latch_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] flag_q, flag_d;
    logic [7:0] pulse_q, pulse_d;
    logic [7:0] prev_q;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_val;
    logic [7:0] clr;
    logic [7:0] fall;

    assign sync_val = sync_q[SYNC_STAGES-1];

    always_comb begin
        latch_d = latch_q;
        mask_d  = mask_q;
        clr     = 8'h00;
        if (wr_en_i) begin
            unique case (reg_sel_i)
                REG_LATCH: latch_d = sfr_bit_write(bb_i, position_i, din_i, bin_i, latch_q);
                REG_MASK:  mask_d  = sfr_bit_write(bb_i, position_i, din_i, bin_i, mask_q);
                REG_FLAG:  clr     = sfr_bit_write(bb_i, position_i, din_i, bin_i, 8'h00);
                default:   ;
            endcase
        end
        // Only a genuine 0->1 latch change earns a strong pull-up cycle.
        pulse_d = latch_d & ~latch_q;
        fall    = prev_q & ~sync_val;
        // A new falling edge wins over a simultaneous W1C clear.
        flag_d  = (flag_q & ~clr) | fall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_q <= PORT_RESET;
            mask_q  <= 8'h00;
            flag_q  <= 8'h00;
            pulse_q <= 8'h00;
            prev_q  <= PORT_RESET;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= PORT_RESET;
            end
        end else begin
            latch_q   <= latch_d;
            mask_q    <= mask_d;
            flag_q    <= flag_d;
            pulse_q   <= pulse_d;
            prev_q    <= sync_val;
            sync_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign latch_o   = latch_q;
    assign mask_o    = mask_q;
    assign flag_o    = flag_q;
    assign sync_o    = sync_val;
    assign pin_oe_o  = ~latch_q | pulse_q;
    assign pin_out_o = latch_q & pulse_q;

endmodule

// File: rtl/mcu_port_bank.sv
// Bank of NPORTS 8051-style quasi-bidirectional ports on the MCU51 SFR bus, with registered
// read data and a combinational interrupt OR over all ports.
module mcu_port_bank
    import mcu51_pkg::*;
#(
    parameter int unsigned NPORTS      = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PSEL_W      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [PSEL_W-1:0]         port_sel,
    input  logic [1:0]                reg_sel,
    input  logic                      Bb,
    input  logic [WIDTH-1:0]          position,
    input  logic                      rmw,
    input  logic [WIDTH-1:0]          din,
    input  logic                      bin,
    output logic [WIDTH-1:0]          dout,
    output logic                      bout,
    output logic                      rd_valid,
    input  logic [NPORTS*WIDTH-1:0]   pin_in,
    output logic [NPORTS*WIDTH-1:0]   pin_out,
    output logic [NPORTS*WIDTH-1:0]   pin_oe,
    output logic                      irq
);

    logic [WIDTH-1:0] latch_w [NPORTS];
    logic [WIDTH-1:0] mask_w  [NPORTS];
    logic [WIDTH-1:0] flag_w  [NPORTS];
    logic [WIDTH-1:0] sync_w  [NPORTS];

    logic [WIDTH-1:0] rd_src;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bout_q, bout_d;
    logic             rd_valid_q;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        mcu_port_slice #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (wr_en && (port_sel == PSEL_W'(p))),
            .reg_sel_i (reg_sel),
            .bb_i      (Bb),
            .position_i(position),
            .din_i     (din),
            .bin_i     (bin),
            .pin_i     (pin_in[WIDTH*p +: WIDTH]),
            .latch_o   (latch_w[p]),
            .mask_o    (mask_w[p]),
            .flag_o    (flag_w[p]),
            .sync_o    (sync_w[p]),
            .pin_out_o (pin_out[WIDTH*p +: WIDTH]),
            .pin_oe_o  (pin_oe[WIDTH*p +: WIDTH])
        );
    end

    // Invalid port indices match no slice and fall through to zero.
    always_comb begin
        rd_src = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (port_sel == PSEL_W'(p)) begin
                case (reg_sel)
                    REG_LATCH: rd_src = rmw ? latch_w[p] : sync_w[p];
                    REG_MASK:  rd_src = mask_w[p];
                    REG_FLAG:  rd_src = flag_w[p];
                    default:   rd_src = '0;
                endcase
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        bout_d = bout_q;
        if (rd_en) begin
            if (Bb) begin
                dout_d = rd_src;
                bout_d = 1'b0;
            end else begin
                dout_d = '0;
                bout_d = |(rd_src & position);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q     <= '0;
            bout_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            bout_q     <= bout_d;
            rd_valid_q <= rd_en;
        end
    end

    always_comb begin
        irq = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            irq = irq | (|(flag_w[p] & mask_w[p]));
        end
    end

    assign dout     = dout_q;
    assign bout     = bout_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mcu_port_bank.sv
// Self-checking bench for mcu_port_bank: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model built from pin history and per-port register arrays.
module tb_mcu_port_bank;

    localparam int NP = 4;
    localparam int S  = 2;
    localparam int PW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en = 1'b0, rd_en = 1'b0;
    logic [PW-1:0]   port_sel = '0;
    logic [1:0]      reg_sel = '0;
    logic            Bb = 1'b1, rmw = 1'b0, bin = 1'b0;
    logic [7:0]      position = '0, din = '0;
    logic [7:0]      dout;
    logic            bout, rd_valid, irq;
    logic [NP*8-1:0] pin_in = '1;
    logic [NP*8-1:0] pin_out, pin_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [7:0]      m_latch [NP];
    logic [7:0]      m_mask  [NP];
    logic [7:0]      m_flag  [NP];
    logic [7:0]      m_pulse [NP];
    logic [NP*8-1:0] m_hist  [S+1];  // m_hist[0] = most recent pin sample
    logic [7:0]      m_dout;
    logic            m_bout, m_rdv;

    mcu_port_bank #(
        .NPORTS(NP), .WIDTH(8), .SYNC_STAGES(S), .PSEL_W(PW)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .port_sel(port_sel),
        .reg_sel(reg_sel), .Bb(Bb), .position(position), .rmw(rmw), .din(din), .bin(bin),
        .dout(dout), .bout(bout), .rd_valid(rd_valid), .pin_in(pin_in), .pin_out(pin_out),
        .pin_oe(pin_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [NP*8-1:0] exp_oe();
        logic [NP*8-1:0] v;
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < 8; i++)
                v[p*8+i] = (m_latch[p][i] == 1'b0) || (m_pulse[p][i] == 1'b1);
        return v;
    endfunction

    function automatic logic [NP*8-1:0] exp_out();
        logic [NP*8-1:0] v;
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < 8; i++)
                v[p*8+i] = m_pulse[p][i];
        return v;
    endfunction

    function automatic logic exp_irq();
        logic r = 1'b0;
        for (int p = 0; p < NP; p++)
            if ((m_flag[p] & m_mask[p]) != 8'h00) r = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_latch[p] = 8'hFF;
            m_mask[p]  = 8'h00;
            m_flag[p]  = 8'h00;
            m_pulse[p] = 8'h00;
        end
        for (int k = 0; k <= S; k++) m_hist[k] = '1;
        m_dout = 8'h00;
        m_bout = 1'b0;
        m_rdv  = 1'b0;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Advance one clock, updating the model from the inputs presented at that edge.
    task automatic step();
        logic [7:0] n_latch [NP];
        logic [7:0] n_mask  [NP];
        logic [7:0] n_flag  [NP];
        logic [7:0] n_pulse [NP];
        logic [7:0] clr, sync_b, prev_b, src, n_dout;
        logic       n_bout, valid;
        logic [NP*8-1:0] pins;
        int ps;
        ps    = int'(port_sel);
        valid = (ps < NP);
        pins  = pin_in;
        for (int p = 0; p < NP; p++) begin
            n_latch[p] = m_latch[p];
            n_mask[p]  = m_mask[p];
            clr        = 8'h00;
            sync_b     = m_hist[S-1][p*8 +: 8];
            prev_b     = m_hist[S][p*8 +: 8];
            if (wr_en && valid && ps == p) begin
                for (int i = 0; i < 8; i++) begin
                    case (reg_sel)
                        2'd0: if (Bb) n_latch[p][i] = din[i];
                              else if (position[i]) n_latch[p][i] = bin;
                        2'd1: if (Bb) n_mask[p][i] = din[i];
                              else if (position[i]) n_mask[p][i] = bin;
                        2'd2: if (Bb ? din[i] : (position[i] && bin)) clr[i] = 1'b1;
                        default: ;
                    endcase
                end
            end
            n_flag[p]  = (m_flag[p] & ~clr) | (prev_b & ~sync_b);
            n_pulse[p] = n_latch[p] & ~m_latch[p];
        end
        n_dout = m_dout;
        n_bout = m_bout;
        if (rd_en) begin
            src = 8'h00;
            if (valid) begin
                case (reg_sel)
                    2'd0: src = rmw ? m_latch[ps] : m_hist[S-1][ps*8 +: 8];
                    2'd1: src = m_mask[ps];
                    2'd2: src = m_flag[ps];
                    default: src = 8'h00;
                endcase
            end
            if (Bb) begin
                n_dout = src;
                n_bout = 1'b0;
            end else begin
                n_dout = 8'h00;
                n_bout = ((src & position) != 8'h00);
            end
        end
        @(posedge clk);
        #1;
        m_latch = n_latch;
        m_mask  = n_mask;
        m_flag  = n_flag;
        m_pulse = n_pulse;
        m_dout  = n_dout;
        m_bout  = n_bout;
        m_rdv   = rd_en;
        for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = pins;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        pin_in = '1;
        #2 reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pin_oe !== '0) begin
            n_fail++; $display("FAIL reset_pin_oe: got %h expected %h", pin_oe, {NP*8{1'b0}});
        end
        n_checks++;
        if (irq !== 1'b0 || rd_valid !== 1'b0 || dout !== 8'h00 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got irq=%b rd_valid=%b dout=%h bout=%b expected 0 0 00 0",
                     irq, rd_valid, dout, bout);
        end
        #4 reset = 1'b0;
        rd_en = 1'b1; port_sel = 3'd0; reg_sel = 2'd0; Bb = 1'b1; rmw = 1'b1;
        step();
        idle();
        n_checks++;
        if (rd_valid !== 1'b1 || dout !== 8'hFF) begin
            n_fail++; $display("FAIL reset_read_latch: got rd_valid=%b dout=%h expected 1 FF",
                               rd_valid, dout);
        end
        step();
        n_checks++;
        if (rd_valid !== 1'b0 || dout !== 8'hFF) begin
            n_fail++; $display("FAIL reset_read_hold: got rd_valid=%b dout=%h expected 0 FF",
                               rd_valid, dout);
        end
    endtask

    task automatic test_pullup();
        wr_en = 1'b1; port_sel = 3'd1; reg_sel = 2'd0; Bb = 1'b1; din = 8'h5A;
        step();
        idle();
        n_checks++;
        if (pin_oe[15:8] !== 8'hA5 || pin_out[15:8] !== 8'h00) begin
            n_fail++; $display("FAIL pullup_write5A: got oe=%h out=%h expected A5 00",
                               pin_oe[15:8], pin_out[15:8]);
        end
        wr_en = 1'b1; din = 8'hFF;
        step();
        idle();
        n_checks++;
        if (pin_oe[15:8] !== 8'hA5 || pin_out[15:8] !== 8'hA5) begin
            n_fail++; $display("FAIL pullup_pulse: got oe=%h out=%h expected A5 A5",
                               pin_oe[15:8], pin_out[15:8]);
        end
        // Rewriting 1 over 1 must not pulse again.
        wr_en = 1'b1; din = 8'hFF;
        step();
        idle();
        n_checks++;
        if (pin_oe[15:8] !== 8'h00 || pin_out[15:8] !== 8'h00) begin
            n_fail++; $display("FAIL pullup_end: got oe=%h out=%h expected 00 00",
                               pin_oe[15:8], pin_out[15:8]);
        end
    endtask

    task automatic test_rmw();
        pin_in[19] = 1'b0;
        repeat (S + 2) step();
        rd_en = 1'b1; port_sel = 3'd2; reg_sel = 2'd0; Bb = 1'b1; rmw = 1'b0;
        step();
        n_checks++;
        if (dout !== 8'hF7) begin
            n_fail++; $display("FAIL rmw_pin_read: got %h expected F7", dout);
        end
        rmw = 1'b1;
        step();
        n_checks++;
        if (dout !== 8'hFF) begin
            n_fail++; $display("FAIL rmw_latch_read: got %h expected FF", dout);
        end
        Bb = 1'b0; position = 8'h08; rmw = 1'b0;
        step();
        n_checks++;
        if (bout !== 1'b0 || dout !== 8'h00) begin
            n_fail++; $display("FAIL rmw_bit_pin: got bout=%b dout=%h expected 0 00", bout, dout);
        end
        rmw = 1'b1;
        step();
        idle();
        n_checks++;
        if (bout !== 1'b1) begin
            n_fail++; $display("FAIL rmw_bit_latch: got %b expected 1", bout);
        end
        pin_in[19] = 1'b1;
        repeat (S + 2) step();
    endtask

    task automatic test_irq();
        wr_en = 1'b1; port_sel = 3'd3; reg_sel = 2'd1; Bb = 1'b1; din = 8'h01;
        step();
        idle();
        pin_in[24] = 1'b0;
        repeat (S) step();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_early: got %b expected 0", irq);
        end
        step();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_set: got %b expected 1", irq);
        end
        pin_in[24] = 1'b1;
        repeat (S + 1) step();
        pin_in[24] = 1'b0;
        repeat (S) step();
        wr_en = 1'b1; reg_sel = 2'd2; Bb = 1'b1; din = 8'h01;
        step();
        idle();
        n_checks++;
        if (irq !== 1'b1 || irq !== exp_irq()) begin
            n_fail++; $display("FAIL irq_set_beats_clear: got %b expected 1", irq);
        end
        wr_en = 1'b1;
        step();
        idle();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_w1c: got %b expected 0", irq);
        end
        pin_in[24] = 1'b1;
        repeat (S + 2) step();
    endtask

    task automatic test_bitwrite();
        wr_en = 1'b1; rd_en = 1'b1; port_sel = 3'd0; reg_sel = 2'd0;
        Bb = 1'b0; position = 8'h80; bin = 1'b0;
        step();
        wr_en = 1'b0;
        n_checks++;
        if (dout !== 8'h00 || bout !== 1'b1) begin
            n_fail++; $display("FAIL bitwrite_prewrite_bitread: got dout=%h bout=%b expected 00 1",
                               dout, bout);
        end
        n_checks++;
        if (pin_oe[7:0] !== 8'h80 || pin_out[7:0] !== 8'h00) begin
            n_fail++; $display("FAIL bitwrite_oe: got oe=%h out=%h expected 80 00",
                               pin_oe[7:0], pin_out[7:0]);
        end
        Bb = 1'b1; rmw = 1'b1;
        step();
        idle();
        n_checks++;
        if (dout !== 8'h7F) begin
            n_fail++; $display("FAIL bitwrite_latch: got %h expected 7F", dout);
        end
        // Same-cycle byte read and write returns the value before the write.
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h33;
        step();
        idle();
        n_checks++;
        if (dout !== 8'h7F) begin
            n_fail++; $display("FAIL bitwrite_rd_prewrite: got %h expected 7F", dout);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en    = ($urandom_range(0, 2) == 0);
            rd_en    = $urandom_range(0, 1) == 1;
            port_sel = PW'($urandom_range(0, 7));
            reg_sel  = 2'($urandom_range(0, 3));
            Bb       = $urandom_range(0, 1) == 1;
            rmw      = $urandom_range(0, 1) == 1;
            bin      = $urandom_range(0, 1) == 1;
            din      = 8'($urandom);
            position = ($urandom_range(0, 1) == 1) ? (8'h01 << $urandom_range(0, 7))
                                                   : 8'($urandom);
            if ($urandom_range(0, 3) == 0) pin_in[$urandom_range(0, NP*8-1)] ^= 1'b1;
            step();
            n_checks++;
            if (pin_oe !== exp_oe()) begin
                n_fail++; $display("FAIL rand_pin_oe c%0d: got %h expected %h", c, pin_oe, exp_oe());
            end
            n_checks++;
            if (pin_out !== exp_out()) begin
                n_fail++; $display("FAIL rand_pin_out c%0d: got %h expected %h",
                                   c, pin_out, exp_out());
            end
            n_checks++;
            if (irq !== exp_irq()) begin
                n_fail++; $display("FAIL rand_irq c%0d: got %b expected %b", c, irq, exp_irq());
            end
            n_checks++;
            if (rd_valid !== m_rdv || dout !== m_dout || bout !== m_bout) begin
                n_fail++;
                $display("FAIL rand_read c%0d: got v=%b d=%h b=%b expected v=%b d=%h b=%b",
                         c, rd_valid, dout, bout, m_rdv, m_dout, m_bout);
            end
        end
        idle();
        pin_in = '1;
        repeat (S + 2) step();
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1; port_sel = 3'd3; reg_sel = 2'd1; Bb = 1'b1; din = 8'hFF;
        step();
        wr_en = 1'b1; port_sel = 3'd0; reg_sel = 2'd0; din = 8'h00;
        step();
        idle();
        pin_in[24] = 1'b0;
        repeat (S + 1) step();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pre_irq: got %b expected 1", irq);
        end
        rd_en = 1'b1; port_sel = 3'd3; reg_sel = 2'd2; Bb = 1'b1;
        step();
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (rd_valid !== 1'b0 || irq !== 1'b0 || pin_oe !== '0 || dout !== 8'h00) begin
            n_fail++; $display("FAIL midreset_async: got v=%b irq=%b oe=%h dout=%h expected 0 0 0 00",
                               rd_valid, irq, pin_oe, dout);
        end
        #1;
        reset = 1'b0;
        rd_en = 1'b0;
        step();
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_no_valid: got %b expected 0", rd_valid);
        end
        rd_en = 1'b1;
        step();
        n_checks++;
        if (dout !== 8'h00 || dout !== m_dout) begin
            n_fail++; $display("FAIL midreset_flags: got %h expected 00", dout);
        end
        port_sel = 3'd0; reg_sel = 2'd0; rmw = 1'b1;
        step();
        idle();
        n_checks++;
        if (dout !== 8'hFF) begin
            n_fail++; $display("FAIL midreset_latch: got %h expected FF", dout);
        end
    endtask

    initial begin
        test_reset();
        test_pullup();
        test_rmw();
        test_irq();
        test_bitwrite();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
